// File: rtl/byte_strip_pkg.sv
// Symbol codes and framing helpers shared by the byte striper.
package byte_strip_pkg;

    // Framing / control symbol codes (compared on D[7:0] only)
    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;

    // Packet-start codes: legal only in lane 0
    function automatic logic is_start_sym(input logic [7:0] d);
        return (d == STP) || (d == SDP);
    endfunction

    // Packet-end codes: legal only in the last lane
    function automatic logic is_end_sym(input logic [7:0] d);
        return (d == END) || (d == EDB);
    endfunction

endpackage

// File: rtl/byte_strip_out_reg.sv
// One-deep output register with ready/valid. A load always wins, so a word
// being handed off downstream can be replaced by the next one on the same edge.
module byte_strip_out_reg #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] q
);

    // Hold the word until taken; a new load replaces it and keeps valid high
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            q         <= din;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_strip_lanes.sv
// Byte striper: deals an input symbol stream round-robin over LANES lanes,
// checks lane placement of framing K-symbols, and emits one parallel word.
// Optional build macro BYTE_STRIP_ERR_CNT_EN adds ERR_CLR / ERR_CNT[15:0],
// a saturating violation counter.
module byte_strip_lanes
    import byte_strip_pkg::*;
#(
    parameter int LANES = 4,
    parameter int BITS  = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [BITS-1:0]       D,
    input  logic                  DK,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [LANES*BITS-1:0] LANE_DATA,
    output logic [LANES-1:0]      LANE_K,
    output logic [LANES-1:0]      LANE_ERR,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
`ifdef BYTE_STRIP_ERR_CNT_EN
    input  logic                  ERR_CLR,
    output logic [15:0]           ERR_CNT,
`endif
    output logic                  ERR
);

    localparam int LW = $clog2(LANES);
    localparam int SW = BITS + 2;            // per-lane slot: {err, k, data}
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    logic [LW-1:0]                 cnt;
    logic [LANES-2:0][BITS-1:0]    stg_d;
    logic [LANES-2:0]              stg_k;
    logic [LANES-2:0]              stg_e;
    logic [LANES-1:0][SW-1:0]      word_d;
    logic [LANES-1:0][SW-1:0]      word_q;
    logic                          last;
    logic                          acc;
    logic                          viol;
    logic                          load;

    assign last     = (cnt == LAST);
    // Only the closing symbol of a word needs the output register free
    assign IN_READY = !(last && OUT_VALID && !OUT_READY);
    assign acc      = IN_VALID && IN_READY;
    assign load     = acc && last;
    assign viol     = DK && ((is_start_sym(D[7:0]) && (cnt != '0)) ||
                             (is_end_sym(D[7:0])   && !last));

    // Lane counter advances only on accepted symbols; power-of-two wraps itself
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt <= '0;
        else if (acc) cnt <= cnt + 1'b1;
    end

    // Staging for lanes 0..LANES-2; the last lane comes straight from D
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stg_d <= '0;
            stg_k <= '0;
            stg_e <= '0;
        end else if (acc && !last) begin
            stg_d[cnt] <= D;
            stg_k[cnt] <= DK;
            stg_e[cnt] <= viol;
        end
    end

    // Assemble the full word and fan the registered word back out per lane
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i < LANES - 1) begin : g_stg
            assign word_d[i] = {stg_e[i], stg_k[i], stg_d[i]};
        end else begin : g_in
            assign word_d[i] = {viol, DK, D};
        end
        assign LANE_DATA[i*BITS +: BITS] = word_q[i][BITS-1:0];
        assign LANE_K[i]                 = word_q[i][BITS];
        assign LANE_ERR[i]               = word_q[i][BITS+1];
    end

    byte_strip_out_reg #(.W(LANES*SW)) u_out (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (load),
        .din       (word_d),
        .out_ready (OUT_READY),
        .out_valid (OUT_VALID),
        .q         (word_q)
    );

    // ERR pulses the cycle after a misplaced framing symbol is accepted
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ERR <= 1'b0;
        else ERR <= acc && viol;
    end

`ifdef BYTE_STRIP_ERR_CNT_EN
    // Saturating violation count; clear takes priority over increment
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ERR_CNT <= '0;
        else if (ERR_CLR) ERR_CNT <= '0;
        else if (acc && viol && (ERR_CNT != 16'hFFFF)) ERR_CNT <= ERR_CNT + 16'd1;
    end
`endif

endmodule

// File: doc/byte_strip_lanes.md
Name: byte_strip_lanes

Overview:
Parametrised byte striper for the PCIe-style physical layer. It distributes a serial stream of symbols (data plus K-flag) round-robin across LANES output lanes and presents them as one parallel word. Each word carries a ready/valid handshake on both sides and per-lane framing checks. It sits between the link-layer symbol source and the per-lane scramblers/serialisers.

Parameters:
LANES, 4, number of output lanes; must be a power of two, 2..16
BITS, 8, symbol width; must be at least 8
LW, $clog2(LANES), lane counter width (derived localparam, not overridable)

Ports:
CLK  in  1  clock, all logic on posedge
RST_N  in  1  asynchronous active-low reset
D  in  BITS  input symbol
DK  in  1  1 = D is a K (control) symbol
IN_VALID  in  1  D/DK valid
IN_READY  out  1  block can accept D this cycle
LANE_DATA  out  LANES*BITS  lane i in bits [i*BITS +: BITS]
LANE_K  out  LANES  per-lane K flag
LANE_ERR  out  LANES  per-lane framing-violation flag
OUT_VALID  out  1  word on LANE_* is complete
OUT_READY  in  1  downstream accepts the word
ERR  out  1  one-cycle pulse on any framing violation

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): lane counter=0; staging cleared; LANE_DATA, LANE_K, LANE_ERR=0; OUT_VALID=0; ERR=0.
- Accept condition: IN_VALID && IN_READY. Only accepted symbols advance the lane counter. Counter wraps LANES-1 -> 0.
- Accepted symbol at counter c < LANES-1: written to staging slot c along with K and err bits.
- Accepted symbol at c = LANES-1: staging slots 0..LANES-2 plus this symbol load the output register on the same edge. OUT_VALID=1 on the next cycle (latency 1 cycle from the last symbol). Staging is then free.
- OUT_VALID && OUT_READY with no new load: OUT_VALID->0. Simultaneous unload and load: the new word replaces the old one and OUT_VALID stays 1.
- IN_READY = !(c==LANES-1 && OUT_VALID && !OUT_READY). It is combinational from OUT_READY. Slots 0..LANES-2 keep filling under backpressure.
- Output word is stable while OUT_VALID && !OUT_READY.
- Framing rule, checked only when DK=1:
  - STP(FB)/SDP(5C) are legal only at c=0.
  - END(FD)/EDB(FE) are legal only at c=LANES-1.
  - COM(BC), SKP(1C), IDL(7C) and data are legal in any lane.
  - Comparisons use D[7:0]; upper bits are ignored when BITS>8.
- On a violation:
  - The symbol is still stored unmodified.
  - Its LANE_ERR bit is set in that word.
  - ERR pulses high for the cycle after acceptance.
  - The counter is not resynchronised.
- DK=0 symbols with framing code values are data and are never errors.
- IN_VALID=0: no state change on the input side; partial staging is held indefinitely.
- Reset mid-word: the partial word is discarded and the counter returns to 0.

Optional Feature:
BYTE_STRIP_ERR_CNT_EN
- Defined:
  - Adds output ERR_CNT [15:0].
  - ERR_CNT increments on each violation and saturates at FFFF.
  - Reset clears it to 0.
  - Adds input ERR_CLR; ERR_CLR=1 clears the count, and clear wins over a simultaneous increment.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Package byte_strip_pkg:
  - Symbol localparams STP, SDP, END, EDB, COM, SKP, IDL (8-bit).
  - Functions is_start_sym(d) and is_end_sym(d).
- One sub-module, byte_strip_out_reg: the 1-deep output register with the valid/ready logic, parametrised by total width.

Test Plan:
1. LANES=4, OUT_READY=1, stream 00,01,02,03,04..07 with DK=0 and IN_VALID=1 continuous -> OUT_VALID in cycles 5 and 9. LANE_DATA=03020100, then 07060504. ERR never asserted.
2. K-stream FB(K),11,22,FD(K) -> one word with LANE_K=1001, LANE_ERR=0000, ERR=0.
3. FB(K) at lane 2 (sequence 00,11,FB-K,33) -> LANE_ERR=0100, one ERR pulse, stored data 33FB1100. With BYTE_STRIP_ERR_CNT_EN, ERR_CNT=1.
4. Backpressure: OUT_READY=0 after the first word, feed 8 symbols -> IN_READY drops when c=3 with 3 symbols staged. Raising OUT_READY loads word 2 the next edge, and word 1 is unchanged until then.
5. IN_VALID toggling 1,0,1,0 on symbols A0..A3 -> word A3A2A1A0 produced, with no gaps filled and no counter advance on idle cycles.
6. Assert RST_N=0 after 2 symbols, release, send 4 symbols -> the first post-reset word holds only the new 4 symbols, and OUT_VALID=0 during reset.
